// File: rtl/pipe_fetch_ctrl.sv
// IF-stage sequencer for a synchronous instruction ROM: PC, next-PC select,
// ROM addressing, IF/ID register and saturating fetch/stall counters.
module pipe_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ROM_AW   = 6
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wpcir,
    input  logic [1:0]        pcsource,
    input  logic [31:0]       bpc,
    input  logic [31:0]       rpc,
    input  logic [31:0]       jpc,
    input  logic [31:0]       rom_q,
    output logic [ROM_AW-1:0] rom_addr,
    output logic [31:0]       pc,
    output logic [31:0]       dpc4,
    output logic [31:0]       inst,
    output logic              d_valid,
    output logic [31:0]       fetch_cnt,
    output logic [31:0]       stall_cnt
);

    typedef enum logic {S_PRIME, S_RUN} state_e;

    localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] dpc4_q, dpc4_d;
    logic [31:0] inst_q, inst_d;
    logic        d_valid_q, d_valid_d;
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    logic [31:0] pc4, npc, npc_al;
    logic        advance;

    assign pc4 = pc_q + 32'h4;

    always_comb begin
        npc = pc4;
        unique case (pcsource)
            2'b00: npc = pc4;
            2'b01: npc = bpc;
            2'b10: npc = rpc;
            2'b11: npc = jpc;
            default: npc = pc4;
        endcase
    end

    // Targets are word aligned by construction; stray low bits are dropped.
    assign npc_al  = npc & ~32'h3;
    assign advance = (state_q == S_RUN) && wpcir;

    // Look ahead to npc when advancing so rom_q always holds the word at pc.
    assign rom_addr = advance ? npc_al[ROM_AW+1:2] : pc_q[ROM_AW+1:2];

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        dpc4_d      = dpc4_q;
        inst_d      = inst_q;
        d_valid_d   = d_valid_q;
        fetch_cnt_d = fetch_cnt_q;
        stall_cnt_d = stall_cnt_q;
        unique case (state_q)
            S_PRIME: begin
                // ROM output is not yet meaningful; spend one edge filling it.
                d_valid_d = 1'b0;
                state_d   = S_RUN;
            end
            S_RUN: begin
                if (wpcir) begin
                    pc_d      = npc_al;
                    inst_d    = rom_q;
                    dpc4_d    = pc4;
                    d_valid_d = 1'b1;
                    if (fetch_cnt_q != CNT_MAX) fetch_cnt_d = fetch_cnt_q + 32'h1;
                end else begin
                    if (stall_cnt_q != CNT_MAX) stall_cnt_d = stall_cnt_q + 32'h1;
                end
            end
            default: state_d = S_PRIME;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_PRIME;
            pc_q        <= RESET_PC;
            dpc4_q      <= 32'h0;
            inst_q      <= 32'h0;
            d_valid_q   <= 1'b0;
            fetch_cnt_q <= 32'h0;
            stall_cnt_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            dpc4_q      <= dpc4_d;
            inst_q      <= inst_d;
            d_valid_q   <= d_valid_d;
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign pc        = pc_q;
    assign dpc4      = dpc4_q;
    assign inst      = inst_q;
    assign d_valid   = d_valid_q;
    assign fetch_cnt = fetch_cnt_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_fetch_ctrl.sv
// Directed bench for pipe_fetch_ctrl with a clocked ROM model holding ROM[i]=0x1000_0000+i.
module tb_pipe_fetch_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        wpcir;
    logic [1:0]  pcsource;
    logic [31:0] bpc, rpc, jpc;
    logic [31:0] rom_q;
    logic [5:0]  rom_addr;
    logic [31:0] pc, dpc4, inst;
    logic        d_valid;
    logic [31:0] fetch_cnt, stall_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] rom [64];

    always #5 clock = ~clock;

    always @(posedge clock) rom_q <= rom[rom_addr];

    pipe_fetch_ctrl #(.RESET_PC(32'h0), .ROM_AW(6)) dut (
        .clock(clock), .reset(reset), .wpcir(wpcir), .pcsource(pcsource),
        .bpc(bpc), .rpc(rpc), .jpc(jpc), .rom_q(rom_q), .rom_addr(rom_addr),
        .pc(pc), .dpc4(dpc4), .inst(inst), .d_valid(d_valid),
        .fetch_cnt(fetch_cnt), .stall_cnt(stall_cnt)
    );

    typedef struct {
        logic        w;
        logic [1:0]  ps;
        logic [31:0] b, r, j;
        logic [5:0]  ra;
        logic [31:0] pc, inst, dpc4;
        logic        v;
        logic [31:0] fc, sc;
    } vec_t;

    vec_t vt [15];

    function automatic vec_t mk(logic w, logic [1:0] ps, logic [31:0] b, logic [31:0] r,
                                logic [31:0] j, logic [5:0] ra, logic [31:0] epc,
                                logic [31:0] einst, logic [31:0] edpc4, logic v,
                                logic [31:0] fc, logic [31:0] sc);
        vec_t t;
        t.w = w; t.ps = ps; t.b = b; t.r = r; t.j = j; t.ra = ra;
        t.pc = epc; t.inst = einst; t.dpc4 = edpc4; t.v = v; t.fc = fc; t.sc = sc;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] R(int i);
        return 32'h1000_0000 + 32'(i);
    endfunction

    task automatic drive(input logic w, input logic [1:0] ps, input logic [31:0] b,
                         input logic [31:0] r, input logic [31:0] j);
        wpcir = w; pcsource = ps; bpc = b; rpc = r; jpc = j;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) rom[i] = R(i);

        //          w  ps     bpc           rpc    jpc            ra  pc             inst    dpc4          v  fc  sc
        vt[0]  = mk(1, 2'b00, 0,            0,     0,             0,  32'h0,         0,      32'h0,        0, 0,  0);
        vt[1]  = mk(1, 2'b00, 0,            0,     0,             1,  32'h4,         R(0),   32'h4,        1, 1,  0);
        vt[2]  = mk(1, 2'b00, 0,            0,     0,             2,  32'h8,         R(1),   32'h8,        1, 2,  0);
        vt[3]  = mk(0, 2'b00, 0,            0,     0,             2,  32'h8,         R(1),   32'h8,        1, 2,  1);
        vt[4]  = mk(0, 2'b00, 0,            0,     0,             2,  32'h8,         R(1),   32'h8,        1, 2,  2);
        vt[5]  = mk(0, 2'b00, 0,            0,     0,             2,  32'h8,         R(1),   32'h8,        1, 2,  3);
        vt[6]  = mk(1, 2'b01, 32'h20,       0,     0,             8,  32'h20,        R(2),   32'hC,        1, 3,  3);
        vt[7]  = mk(1, 2'b00, 0,            0,     0,             9,  32'h24,        R(8),   32'h24,       1, 4,  3);
        vt[8]  = mk(0, 2'b11, 0,            0,     32'h30,        9,  32'h24,        R(8),   32'h24,       1, 4,  4);
        vt[9]  = mk(1, 2'b10, 0,            32'h13, 0,            4,  32'h10,        R(9),   32'h28,       1, 5,  4);
        vt[10] = mk(1, 2'b11, 0,            0,     32'hFFFF_FFFC, 63, 32'hFFFF_FFFC, R(4),   32'h14,       1, 6,  4);
        vt[11] = mk(1, 2'b00, 0,            0,     0,             0,  32'h0,         R(63),  32'h0,        1, 7,  4);
        vt[12] = mk(1, 2'b00, 0,            0,     0,             1,  32'h4,         R(0),   32'h4,        1, 8,  4);
        vt[13] = mk(1, 2'b01, 32'h0000_0102, 0,    0,             0,  32'h100,       R(1),   32'h8,        1, 9,  4);
        vt[14] = mk(1, 2'b00, 0,            0,     0,             1,  32'h104,       R(0),   32'h104,      1, 10, 4);

        reset = 1'b1;
        drive(1'b1, 2'b00, 0, 0, 0);
        #1;
        chk("rst_pc", pc, 32'h0);
        chk("rst_inst", inst, 32'h0);
        chk("rst_dpc4", dpc4, 32'h0);
        chk("rst_valid", 32'(d_valid), 32'h0);
        chk("rst_fcnt", fetch_cnt, 32'h0);
        chk("rst_scnt", stall_cnt, 32'h0);
        repeat (2) @(negedge clock);
        reset = 1'b0;

        for (int k = 0; k < 15; k++) begin
            drive(vt[k].w, vt[k].ps, vt[k].b, vt[k].r, vt[k].j);
            #1;
            chk($sformatf("v%0d_rom_addr", k), 32'(rom_addr), 32'(vt[k].ra));
            @(posedge clock);
            #1;
            chk($sformatf("v%0d_pc", k), pc, vt[k].pc);
            chk($sformatf("v%0d_inst", k), inst, vt[k].inst);
            chk($sformatf("v%0d_dpc4", k), dpc4, vt[k].dpc4);
            chk($sformatf("v%0d_valid", k), 32'(d_valid), 32'(vt[k].v));
            chk($sformatf("v%0d_fcnt", k), fetch_cnt, vt[k].fc);
            chk($sformatf("v%0d_scnt", k), stall_cnt, vt[k].sc);
            @(negedge clock);
        end

        // Mid-cycle reset clears everything without waiting for an edge.
        drive(1'b1, 2'b00, 0, 0, 0);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_pc", pc, 32'h0);
        chk("mid_rst_inst", inst, 32'h0);
        chk("mid_rst_dpc4", dpc4, 32'h0);
        chk("mid_rst_valid", 32'(d_valid), 32'h0);
        chk("mid_rst_fcnt", fetch_cnt, 32'h0);
        chk("mid_rst_scnt", stall_cnt, 32'h0);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock); #1;
        chk("prime_valid", 32'(d_valid), 32'h0);
        chk("prime_pc", pc, 32'h0);
        @(posedge clock); #1;
        chk("first_valid", 32'(d_valid), 32'h1);
        chk("first_inst", inst, R(0));
        chk("first_pc", pc, 32'h4);

        // Fetch counter saturation.
        @(negedge clock);
        force dut.fetch_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.fetch_cnt_q;
        #1;
        chk("sat_f_preload", fetch_cnt, 32'hFFFF_FFFE);
        for (int c = 1; c <= 3; c++) begin
            @(posedge clock); #1;
            chk($sformatf("sat_f_%0d", c), fetch_cnt, 32'hFFFF_FFFF);
        end

        // Stall counter saturation.
        @(negedge clock);
        drive(1'b0, 2'b00, 0, 0, 0);
        force dut.stall_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.stall_cnt_q;
        for (int c = 1; c <= 3; c++) begin
            @(posedge clock); #1;
            chk($sformatf("sat_s_%0d", c), stall_cnt, 32'hFFFF_FFFF);
        end
        chk("sat_s_fhold", fetch_cnt, 32'hFFFF_FFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
